// File: rtl/hwpe_stream_pack_if.sv
// Ready/valid stream bundle shared by the packer's narrow input and wide output.
// strb carries one enable bit per data byte.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic clk
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
  modport master (output valid, data, strb, input ready);
  modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_pack.sv
// Packs NB_BEATS narrow stream beats (first beat in the LSBs) into one registered wide word.
// Partial-word flush (flush_i) is compiled in only when HWPE_STREAM_PACK_FLUSH_EN is defined.
module hwpe_stream_pack #(
  parameter int unsigned NB_BEATS      = 2,
  parameter int unsigned DATA_WIDTH_IN = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic clear_i,
`ifdef HWPE_STREAM_PACK_FLUSH_EN
  input logic flush_i,
`endif
  hwpe_stream_intf_stream.sink   stream_i,
  hwpe_stream_intf_stream.source stream_o
);
  localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN * NB_BEATS;
  localparam int unsigned STRB_WIDTH_IN  = DATA_WIDTH_IN / 8;
  localparam int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / 8;
  localparam int unsigned CNT_W          = $clog2(NB_BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NB_BEATS - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH_OUT-1:0] acc_data_q, acc_data_d;
  logic [STRB_WIDTH_OUT-1:0] acc_strb_q, acc_strb_d;
  logic [DATA_WIDTH_OUT-1:0] out_data_q, out_data_d;
  logic [STRB_WIDTH_OUT-1:0] out_strb_q, out_strb_d;
  logic                      out_valid_q, out_valid_d;
  logic                      flush_pend_q, flush_pend_d;

  logic out_free;
  logic in_ready;
  logic accept;
  logic last_beat;

  always_comb begin
    out_free  = !out_valid_q || stream_o.ready;
    last_beat = (cnt_q == LAST_CNT);
    // Only the completing beat needs the output register; earlier beats go to the buffer.
    in_ready  = !(rst_i || clear_i) && !flush_pend_q && (!last_beat || out_free);
    accept    = stream_i.valid && in_ready;
  end

  always_comb begin
    cnt_d        = cnt_q;
    acc_data_d   = acc_data_q;
    acc_strb_d   = acc_strb_q;
    out_data_d   = out_data_q;
    out_strb_d   = out_strb_q;
    out_valid_d  = out_valid_q;
    flush_pend_d = flush_pend_q;

    if (out_valid_q && stream_o.ready) out_valid_d = 1'b0;

    if (accept) begin
      for (int unsigned k = 0; k < NB_BEATS; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          acc_data_d[k*DATA_WIDTH_IN +: DATA_WIDTH_IN] = stream_i.data;
          acc_strb_d[k*STRB_WIDTH_IN +: STRB_WIDTH_IN] = stream_i.strb;
        end
      end
      if (last_beat) begin
        out_data_d  = acc_data_d;
        out_strb_d  = acc_strb_d;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        acc_data_d  = '0;
        acc_strb_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

`ifdef HWPE_STREAM_PACK_FLUSH_EN
    // Buffer slots above cnt are still zero, so the partial word is zero-padded as-is.
    if (flush_pend_q) begin
      if (out_free) begin
        out_data_d   = acc_data_q;
        out_strb_d   = acc_strb_q;
        out_valid_d  = 1'b1;
        cnt_d        = '0;
        acc_data_d   = '0;
        acc_strb_d   = '0;
        flush_pend_d = 1'b0;
      end
    end else if (flush_i && !(accept && last_beat) && (cnt_q != '0 || accept)) begin
      flush_pend_d = 1'b1;
    end
`else
    flush_pend_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q        <= '0;
      acc_data_q   <= '0;
      acc_strb_q   <= '0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_data_q   <= acc_data_d;
      acc_strb_q   <= acc_strb_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    stream_i.ready = in_ready;
    stream_o.valid = out_valid_q;
    stream_o.data  = out_data_q;
    stream_o.strb  = out_strb_q;
  end
endmodule

// File: tb/tb_hwpe_stream_pack.sv
// Randomized and directed bench for hwpe_stream_pack (NB_BEATS=4, 32-bit beats) against a
// beat-queue reference model; flush scenarios run when HWPE_STREAM_PACK_FLUSH_EN is defined.
module tb_hwpe_stream_pack;
  localparam int unsigned NB = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned WO = W * NB;
  localparam int unsigned SI = W / 8;
  localparam int unsigned SO = WO / 8;
`ifdef HWPE_STREAM_PACK_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic clear_i = 1'b0;
  logic flush_tb = 1'b0;
  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(W))  s_in  (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(WO)) s_out (.clk(clk));

  hwpe_stream_pack #(.NB_BEATS(NB), .DATA_WIDTH_IN(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
`ifdef HWPE_STREAM_PACK_FLUSH_EN
    .flush_i  (flush_tb),
`endif
    .stream_i (s_in),
    .stream_o (s_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // drive values applied on the next tick
  bit          d_rst, d_clr, d_v, d_ordy, d_fl;
  logic [W-1:0]  d_data;
  logic [SI-1:0] d_strb;
  bit          last_acc;

  // reference model: accepted beats waiting to be packed, plus the expected output register
  logic [W-1:0]  bq_d[$];
  logic [SI-1:0] bq_s[$];
  logic [WO-1:0] m_data = '0;
  logic [SO-1:0] m_strb = '0;
  bit            m_valid = 1'b0;
  bit            m_pend = 1'b0;

  task automatic pack_queue();
    m_data = '0;
    m_strb = '0;
    for (int i = 0; i < bq_d.size(); i++) begin
      m_data[i*W +: W]   = bq_d[i];
      m_strb[i*SI +: SI] = bq_s[i];
    end
    m_valid = 1'b1;
    bq_d.delete();
    bq_s.delete();
  endtask

  task automatic tick();
    bit exp_rdy, acc, free;
    @(negedge clk);
    rst_i       = d_rst;
    clear_i     = d_clr;
    flush_tb    = d_fl;
    s_in.valid  = d_v;
    s_in.data   = d_data;
    s_in.strb   = d_strb;
    s_out.ready = d_ordy;
    #1;
    free    = !m_valid || d_ordy;
    exp_rdy = !(d_rst || d_clr) && !m_pend && (bq_d.size() < NB - 1 || free);
    check_eq("in_ready", s_in.ready, exp_rdy);
    check_eq("out_valid", s_out.valid, m_valid);
    if (m_valid) begin
      check_eq("out_data", s_out.data, m_data);
      check_eq("out_strb", s_out.strb, m_strb);
    end
    acc = d_v && exp_rdy;
    last_acc = acc;
    if (d_rst || d_clr) begin
      bq_d.delete();
      bq_s.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_strb  = '0;
      m_pend  = 1'b0;
    end else begin
      if (m_valid && d_ordy) m_valid = 1'b0;
      if (acc) begin
        bq_d.push_back(d_data);
        bq_s.push_back(d_strb);
      end
      if (bq_d.size() == NB) pack_queue();
      else if (m_pend) begin
        if (free) begin
          pack_queue();
          m_pend = 1'b0;
        end
      end else if (d_fl && bq_d.size() > 0) m_pend = 1'b1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic [SI-1:0] s);
    d_v = 1'b1;
    d_data = d;
    d_strb = s;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    check_eq("send_accepted", last_acc, 1'b1);
    d_v = 1'b0;
  endtask

  task automatic idle(input int n);
    d_v = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    s_in.valid = 1'b0;
    s_in.data = '0;
    s_in.strb = '0;
    s_out.ready = 1'b0;
    d_rst = 1; d_clr = 0; d_v = 0; d_ordy = 1; d_fl = 0; d_data = '0; d_strb = '0;
    idle(2);
    d_rst = 0;
    idle(1);
    check_eq("reset_valid", s_out.valid, 1'b0);
    check_eq("reset_data", s_out.data, '0);

    // four beats into one word, first beat in the LSB slice
    send(32'h11111111, 4'hF);
    send(32'h22222222, 4'hF);
    send(32'h33333333, 4'hF);
    send(32'h44444444, 4'hF);
    idle(1);
    check_eq("word_data", s_out.data, 128'h44444444_33333333_22222222_11111111);
    check_eq("word_strb", s_out.strb, 16'hFFFF);
    idle(2);

    // back-to-back beats with ready high: input ready must stay high throughout
    for (int i = 0; i < 8; i++) send(32'hC0DE0000 + i, 4'hF);
    idle(2);

    // output back-pressure: 5th-7th beats accepted, 8th beat stalls until the word drains
    d_ordy = 0;
    for (int i = 0; i < 7; i++) send(32'h50000000 + i, 4'(i + 1));
    d_v = 1; d_data = 32'h5000_0007; d_strb = 4'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_beat", last_acc, 1'b0);
    end
    d_ordy = 1;
    tick();
    check_eq("stall_release", last_acc, 1'b1);
    idle(3);

    // soft clear drops a partial word
    send(32'hDEAD0001, 4'hF);
    send(32'hDEAD0002, 4'hF);
    d_clr = 1; idle(1); d_clr = 0;
    check_eq("clear_valid", s_out.valid, 1'b0);
    send(32'hA, 4'hF); send(32'hB, 4'hF); send(32'hC, 4'hF); send(32'hD, 4'hF);
    idle(1);
    check_eq("after_clear", s_out.data, 128'h0000000D_0000000C_0000000B_0000000A);
    idle(1);

    // reset with a word held
    d_ordy = 0;
    for (int i = 0; i < 4; i++) send(32'h77770000 + i, 4'hF);
    idle(1);
    d_rst = 1; idle(1); d_rst = 0;
    idle(1);
    check_eq("rst_valid", s_out.valid, 1'b0);
    check_eq("rst_data", s_out.data, '0);
    check_eq("rst_strb", s_out.strb, '0);
    d_ordy = 1;

    if (FLUSH_EN) begin
      send(32'hAAAAAAAA, 4'hF);
      send(32'hBBBBBBBB, 4'hF);
      d_fl = 1; idle(1); d_fl = 0;
      idle(2);
      check_eq("flush_data", s_out.data, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
      check_eq("flush_strb", s_out.strb, 16'h00FF);
      idle(2);
      d_fl = 1; idle(1); d_fl = 0;
      idle(2);
      check_eq("flush_empty", s_out.valid, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_rst  = ($urandom_range(0, 199) == 0);
      d_clr  = ($urandom_range(0, 79) == 0);
      d_v    = ($urandom_range(0, 3) != 0);
      d_data = $urandom;
      d_strb = 4'($urandom);
      d_ordy = ($urandom_range(0, 9) < 7);
      d_fl   = FLUSH_EN && ($urandom_range(0, 15) == 0);
      tick();
    end
    d_rst = 0; d_clr = 0; d_fl = 0; d_ordy = 1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/hwpe_stream_pack.md
HWPE_STREAM_PACK -- requirements
Module: hwpe_stream_pack

Interface
REQ-001 SHALL have parameter NB_BEATS, default 2: number of narrow beats packed into one wide word (>=2).
REQ-002 SHALL have parameter DATA_WIDTH_IN, default 32: narrow input data width in bits (multiple of 8).
REQ-003 SHALL derive DATA_WIDTH_OUT = DATA_WIDTH_IN*NB_BEATS, STRB_WIDTH_IN = DATA_WIDTH_IN/8, STRB_WIDTH_OUT = DATA_WIDTH_OUT/8.
REQ-004 SHALL have clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have clear_i  input  1  synchronous soft clear, active-high.
REQ-007 SHALL have stream_i  hwpe_stream_intf_stream.sink  DATA_WIDTH_IN data / STRB_WIDTH_IN strb  narrow input stream.
REQ-008 SHALL have stream_o  hwpe_stream_intf_stream.source  DATA_WIDTH_OUT data / STRB_WIDTH_OUT strb  packed wide output stream.
REQ-009 SHALL have flush_i  input  1  partial-word flush request, present only with HWPE_STREAM_PACK_FLUSH_EN.

Function
REQ-010 SHALL accept an input beat when stream_i.valid and stream_i.ready are both 1 in the same cycle; emit a word when stream_o.valid and stream_o.ready are both 1.
REQ-011 SHALL keep beat counter cnt, range 0..NB_BEATS-1, incremented per accepted beat, wrapping to 0 after beat NB_BEATS-1.
REQ-012 SHALL place accepted beat k (k = cnt) into data slice [(k+1)*DATA_WIDTH_IN-1 : k*DATA_WIDTH_IN] and strb slice [(k+1)*STRB_WIDTH_IN-1 : k*STRB_WIDTH_IN]; first beat is LSB.
REQ-013 SHALL collect beats 0..NB_BEATS-2 in an accumulation buffer separate from the output register.
REQ-014 SHALL, on accepting beat NB_BEATS-1, load accumulation buffer plus that beat into the output register and set stream_o.valid the next cycle (1-cycle latency).
REQ-015 SHALL drive stream_i.ready = 1 when cnt < NB_BEATS-1; when cnt = NB_BEATS-1, stream_i.ready = !stream_o.valid || stream_o.ready.
REQ-016 SHALL sustain one input beat per cycle with output ready held high: one wide word every NB_BEATS cycles, no bubbles.
REQ-017 SHALL hold stream_o.data/strb/valid stable while stream_o.valid=1 and stream_o.ready=0.
REQ-018 SHALL, when a word is emitted and a new word loaded in the same cycle, keep stream_o.valid=1 with the new contents.
REQ-019 SHALL never combinationally depend stream_o.valid on stream_i.valid (registered output).

Reset
REQ-020 SHALL, when rst_i=1 at a clock edge, set cnt=0, stream_o.valid=0, output data/strb=0, accumulation buffer=0, flush pending=0.
REQ-021 SHALL, when clear_i=1 (rst_i=0), apply the same effect as REQ-020, discarding any partial or pending word; rst_i has priority.
REQ-022 SHALL drive stream_i.ready=0 during a cycle where rst_i or clear_i is 1.

Configuration
REQ-023 SHALL compile flush support only when macro HWPE_STREAM_PACK_FLUSH_EN is defined; without it, flush_i absent and only full words are emitted.
REQ-024 SHALL, with the macro, latch flush_i=1 into a pending flag if cnt>0 (or a beat accepted the same cycle makes cnt>0); flush_i with cnt=0 and no beat is ignored.
REQ-025 SHALL, while flush pending, drive stream_i.ready=0; when output register free (!stream_o.valid || stream_o.ready), load partial word, unfilled strb slices=0, unfilled data slices=0, cnt=0, clear pending.
REQ-026 SHALL, if the beat accepted with flush_i completes a word, emit the full word normally and not set pending.

Verification
REQ-027 NB_BEATS=4, DATA_WIDTH_IN=32, ready=1, beats 0x11111111,0x22222222,0x33333333,0x44444444, strb 0xF -> one cycle after 4th beat: data=0x44444444_33333333_22222222_11111111, strb=0xFFFF.
REQ-028 Continuous 8 beats, ready=1 -> two words, valid on cycles 4 and 8 after first beat, stream_i.ready never 0.
REQ-029 Output ready=0 while word held, 4 more beats sent -> beats 0-2 accepted, beat 3 stalled (stream_i.ready=0), word 1 stable; ready=1 -> word 1 emitted, beat 3 accepted same cycle, word 2 valid next cycle.
REQ-030 clear_i pulsed after 2 beats -> cnt=0, stream_o.valid=0; next 4 beats 0xA..0xD form one word with 0xA in LSB slice.
REQ-031 Flush macro on, 2 beats 0xAAAAAAAA,0xBBBBBBBB then flush_i -> data=0x00000000_00000000_BBBBBBBB_AAAAAAAA, strb=0x00FF; flush_i with cnt=0 -> no output.
REQ-032 rst_i asserted with valid word held -> next cycle stream_o.valid=0, data=0, strb=0.
